// File: rtl/uart_rx_core_if.sv
// Receive-side bundle of uart_rx_core: serial line, divisor, byte stream and status.
// The core drives the byte stream through the master modport. The consumer uses the slave modport.
interface uart_rx_core_if #(
    parameter int DIV_WID    = 4,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DIV_WID-1:0]            div_factor;
    logic                          uart_rxd;
    logic [DATA_BITS-1:0]          rx_data;
    logic                          rx_valid;
    logic                          rx_ready;
    logic                          frame_err;
    logic                          overflow;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        input  div_factor, uart_rxd, rx_ready,
        output rx_data, rx_valid, frame_err, overflow, fifo_level
    );

    modport slave (
        output div_factor, uart_rxd, rx_ready,
        input  rx_data, rx_valid, frame_err, overflow, fifo_level
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver that uses 16x oversampling and feeds a show-ahead FIFO.
// The FIFO is drained by a valid/ready pop. Framing errors and overflow are reported as single-cycle pulses.
module uart_rx_core #(
    parameter int DIV_WID    = 4,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           hclk,
    input  logic           hresetn,
    uart_rx_core_if.master rx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    function automatic logic [DIV_WID-1:0] eff_div(input logic [DIV_WID-1:0] d);
        if (d == {DIV_WID{1'b0}}) begin
            eff_div = DIV_WID'(1);
        end else begin
            eff_div = d;
        end
    endfunction

    logic                 rxd_meta_r;
    logic                 rxd_sync_r;
    logic [DIV_WID-1:0]   div_lat_r;
    logic [DIV_WID-1:0]   div_eff_s;
    logic [DIV_WID-1:0]   tick_cnt_r;
    logic                 tick_s;
    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [3:0]           s_cnt_r;
    logic [BW-1:0]        bit_cnt_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 push_req_s;
    logic                 ferr_s;

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [PW-1:0]        rd_ptr_inc_s;
    logic [LW-1:0]        level_r;
    logic [LW-1:0]        level_nxt_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_ok_s;
    logic                 ovf_s;
    logic [DATA_BITS-1:0] head_nxt_s;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 frame_err_r;
    logic                 overflow_r;

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rx.uart_rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    // Oversample tick: idle follows the live divisor, a frame uses the value latched at start
    always_comb begin
        if (state_r == ST_IDLE) begin
            div_eff_s = eff_div(rx.div_factor);
        end else begin
            div_eff_s = div_lat_r;
        end
        tick_s = (tick_cnt_r >= (div_eff_s - DIV_WID'(1)));
    end

    // Oversample tick counter
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            tick_cnt_r <= {DIV_WID{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {DIV_WID{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + DIV_WID'(1);
        end
    end

    // Frame FSM next-state, push request and framing-error decode
    always_comb begin
        state_nxt_s = state_r;
        push_req_s  = 1'b0;
        ferr_s      = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxd_sync_r) state_nxt_s = ST_START;
                    else             state_nxt_s = ST_IDLE;
                end
                ST_START: begin
                    if (s_cnt_r == 4'd7) state_nxt_s = rxd_sync_r ? ST_IDLE : ST_DATA;
                    else                 state_nxt_s = ST_START;
                end
                ST_DATA: begin
                    if ((s_cnt_r == 4'd15) && (bit_cnt_r == LAST_BIT)) state_nxt_s = ST_STOP;
                    else                                               state_nxt_s = ST_DATA;
                end
                ST_STOP: begin
                    if (s_cnt_r == 4'd15) begin
                        if (rxd_sync_r) begin
                            push_req_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            ferr_s      = 1'b1;
                            state_nxt_s = ST_BREAK;
                        end
                    end else begin
                        state_nxt_s = ST_STOP;
                    end
                end
                ST_BREAK: begin
                    if (rxd_sync_r) state_nxt_s = ST_IDLE;
                    else            state_nxt_s = ST_BREAK;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state, per-state tick count, divisor latch and data shifter
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_r   <= ST_IDLE;
            s_cnt_r   <= 4'd0;
            bit_cnt_r <= {BW{1'b0}};
            shift_r   <= {DATA_BITS{1'b0}};
            div_lat_r <= DIV_WID'(1);
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                s_cnt_r <= 4'd0;
            end else if (tick_s) begin
                s_cnt_r <= s_cnt_r + 4'd1;
            end
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_START)) begin
                div_lat_r <= div_eff_s;
            end
            if ((state_r == ST_START) && (state_nxt_s == ST_DATA)) begin
                bit_cnt_r <= {BW{1'b0}};
            end else if ((state_r == ST_DATA) && tick_s && (s_cnt_r == 4'd15)) begin
                shift_r   <= {rxd_sync_r, shift_r[DATA_BITS-1:1]};
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end
        end
    end

    // FIFO control; a push into a full FIFO succeeds only when a pop frees a slot in the same cycle
    always_comb begin
        full_s       = (level_r == FULL_LVL);
        pop_s        = rx.rx_ready & rx_valid_r;
        push_ok_s    = push_req_s & (~full_s | pop_s);
        ovf_s        = push_req_s & full_s & ~pop_s;
        rd_ptr_inc_s = rd_ptr_r + PW'(1);
        if (push_ok_s && !pop_s) begin
            level_nxt_s = level_r + LW'(1);
        end else if (!push_ok_s && pop_s) begin
            level_nxt_s = level_r - LW'(1);
        end else begin
            level_nxt_s = level_r;
        end
        if (pop_s) begin
            if (level_r > LW'(1))  head_nxt_s = mem_r[rd_ptr_inc_s];
            else if (push_ok_s)    head_nxt_s = shift_r;
            else                   head_nxt_s = rx_data_r;
        end else if (push_ok_s && (level_r == LW'(0))) begin
            head_nxt_s = shift_r;
        end else begin
            head_nxt_s = rx_data_r;
        end
    end

    // FIFO storage, pointers, registered head and status pulses
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_BITS{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            level_r     <= {LW{1'b0}};
            rx_data_r   <= {DATA_BITS{1'b0}};
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_inc_s;
            end
            level_r     <= level_nxt_s;
            rx_data_r   <= head_nxt_s;
            rx_valid_r  <= (level_nxt_s != LW'(0));
            frame_err_r <= ferr_s;
            overflow_r  <= ovf_s;
        end
    end

    assign rx.rx_data    = rx_data_r;
    assign rx.rx_valid   = rx_valid_r;
    assign rx.frame_err  = frame_err_r;
    assign rx.overflow   = overflow_r;
    assign rx.fifo_level = level_r;
endmodule
